sockit_spi_flash_rsp: RTL and testbench

// - SPI flash responder (slave): the device-side end of the XIP read protocol.
// - Decodes a single-line SPI mode-0 transaction: 8-bit command, 24-bit address,
//   8 dummy clocks, then streams bytes read from a local memory port.
// - Oversamples SCLK/CS_N/SIO with clk (requires f_clk >= 8*f_sclk).
// - Used as a synthesizable flash stand-in for system/XIP verification.

---
 rtl/sockit_spi_flash_rsp_if.sv | 25 ++
 rtl/sockit_spi_flash_rsp.sv | 165 ++++++++++++++++
 tb/tb_sockit_spi_flash_rsp.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sockit_spi_flash_rsp_if.sv
// SPI pins and local memory read port of the flash responder, bundled as one interface.
// The responder uses the slave modport; the host/memory side uses the master modport.
interface sockit_spi_flash_rsp_if #(
  parameter int unsigned AW = 24
);
  logic          spi_cs_n;
  logic          spi_sclk;
  logic [3:0]    spi_sio_i;
  logic [3:0]    spi_sio_o;
  logic [3:0]    spi_sio_e;
  logic          mem_ren;
  logic [AW-1:0] mem_adr;
  logic [7:0]    mem_rdt;
  logic          err_cmd;

  modport slave (
    input  spi_cs_n, spi_sclk, spi_sio_i, mem_rdt,
    output spi_sio_o, spi_sio_e, mem_ren, mem_adr, err_cmd
  );

  modport master (
    output spi_cs_n, spi_sclk, spi_sio_i, mem_rdt,
    input  spi_sio_o, spi_sio_e, mem_ren, mem_adr, err_cmd
  );
endinterface

// File: rtl/sockit_spi_flash_rsp.sv
// SPI flash responder: oversampled mode-0 fast read (0x0B) streaming bytes from a memory port.
// Define SOCKIT_SPI_FLASH_QUAD_EN to also accept quad output fast read (0x6B).
module sockit_spi_flash_rsp #(
  parameter int unsigned AW  = 24,
  parameter int unsigned SYN = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  sockit_spi_flash_rsp_if.slave         bus
);

  typedef enum logic [2:0] {StIdl, StCmd, StAdr, StDmy, StDat, StIgn} state_e;

  state_e        state_q;
  logic [SYN-1:0] cs_q, sclk_q, sio_q;
  logic          sclk_p;
  logic [4:0]    cnt_q;
  logic [22:0]   sreg_q;
  logic [2:0]    bcnt_q;
  logic [7:0]    rbuf_q, dsr_q;
  logic          ren_q, fill_q, err_q, doe_q;
  logic [AW-1:0] adr_q;
`ifdef SOCKIT_SPI_FLASH_QUAD_EN
  logic          quad_q;
  logic [3:0]    dout_q;
`else
  logic          dout_q;
`endif

  logic        cs_s, sclk_s, sio_s, rise, fall;
  logic [23:0] shin;
  logic [7:0]  src;
  logic        unused_sio;

  assign cs_s       = cs_q[SYN-1];
  assign sclk_s     = sclk_q[SYN-1];
  assign sio_s      = sio_q[SYN-1];
  assign rise       = sclk_s & ~sclk_p;
  assign fall       = ~sclk_s & sclk_p;
  assign shin       = {sreg_q, sio_s};
  // Byte boundary takes the freshly fetched byte, otherwise keep shifting.
  assign src        = (bcnt_q == 3'd0) ? rbuf_q : dsr_q;
  assign unused_sio = ^bus.spi_sio_i[3:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdl;
      cs_q    <= '1;
      sclk_q  <= '0;
      sio_q   <= '0;
      sclk_p  <= 1'b0;
      cnt_q   <= '0;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      rbuf_q  <= '0;
      dsr_q   <= '0;
      ren_q   <= 1'b0;
      fill_q  <= 1'b0;
      err_q   <= 1'b0;
      doe_q   <= 1'b0;
      adr_q   <= '0;
      dout_q  <= '0;
`ifdef SOCKIT_SPI_FLASH_QUAD_EN
      quad_q  <= 1'b0;
`endif
    end else begin
      cs_q   <= {cs_q[SYN-2:0], bus.spi_cs_n};
      sclk_q <= {sclk_q[SYN-2:0], bus.spi_sclk};
      sio_q  <= {sio_q[SYN-2:0], bus.spi_sio_i[0]};
      sclk_p <= sclk_s;
      ren_q  <= 1'b0;
      err_q  <= 1'b0;
      fill_q <= ren_q;
      if (fill_q) rbuf_q <= bus.mem_rdt;

      // Deselect overrides any sclk edge seen in the same sample.
      if (cs_s) begin
        state_q <= StIdl;
        cnt_q   <= '0;
        doe_q   <= 1'b0;
        dout_q  <= '0;
      end else begin
        unique case (state_q)
          StIdl: begin
            state_q <= StCmd;
            cnt_q   <= '0;
          end
          StCmd: if (rise) begin
            sreg_q <= shin[22:0];
            cnt_q  <= cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_q <= '0;
              if (shin[7:0] == 8'h0B) begin
                state_q <= StAdr;
`ifdef SOCKIT_SPI_FLASH_QUAD_EN
                quad_q  <= 1'b0;
              end else if (shin[7:0] == 8'h6B) begin
                state_q <= StAdr;
                quad_q  <= 1'b1;
`endif
              end else begin
                state_q <= StIgn;
                err_q   <= 1'b1;
              end
            end
          end
          StAdr: if (rise) begin
            sreg_q <= shin[22:0];
            cnt_q  <= cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              adr_q   <= shin[AW-1:0];
              cnt_q   <= '0;
              state_q <= StDmy;
            end
          end
          StDmy: if (rise) begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_q   <= '0;
              ren_q   <= 1'b1;
              bcnt_q  <= '0;
              state_q <= StDat;
            end
          end
          StDat: if (fall) begin
            doe_q <= 1'b1;
            if (bcnt_q == 3'd0) begin
              adr_q <= adr_q + AW'(1);
              ren_q <= 1'b1;
            end
`ifdef SOCKIT_SPI_FLASH_QUAD_EN
            if (quad_q) begin
              dout_q <= src[7:4];
              dsr_q  <= {src[3:0], 4'h0};
              bcnt_q <= bcnt_q + 3'd4;
            end else begin
              dout_q <= {2'b00, src[7], 1'b0};
              dsr_q  <= {src[6:0], 1'b0};
              bcnt_q <= bcnt_q + 3'd1;
            end
`else
            dout_q <= src[7];
            dsr_q  <= {src[6:0], 1'b0};
            bcnt_q <= bcnt_q + 3'd1;
`endif
          end
          StIgn: ;
          default: state_q <= StIdl;
        endcase
      end
    end
  end

  assign bus.mem_ren = ren_q;
  assign bus.mem_adr = adr_q;
  assign bus.err_cmd = err_q;
`ifdef SOCKIT_SPI_FLASH_QUAD_EN
  assign bus.spi_sio_o = dout_q;
  assign bus.spi_sio_e = doe_q ? (quad_q ? 4'hF : 4'h2) : 4'h0;
`else
  assign bus.spi_sio_o = {2'b00, dout_q, 1'b0};
  assign bus.spi_sio_e = {2'b00, doe_q, 1'b0};
`endif

endmodule

// File: tb/tb_sockit_spi_flash_rsp.sv
// Directed bench for sockit_spi_flash_rsp: a 24-bit and an 8-bit address instance share
// the SPI host stimulus; each has its own memory model and event logs.
module tb_sockit_spi_flash_rsp;

  localparam int H = 8;  // sclk half period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       sclk = 1'b0;
  logic       sio0 = 1'b0;
  logic [7:0] mem [0:255];

  sockit_spi_flash_rsp_if #(.AW(24)) bus ();
  sockit_spi_flash_rsp_if #(.AW(8))  bus8 ();

  assign bus.spi_cs_n   = cs_n;
  assign bus.spi_sclk   = sclk;
  assign bus.spi_sio_i  = {3'b000, sio0};
  assign bus8.spi_cs_n  = cs_n;
  assign bus8.spi_sclk  = sclk;
  assign bus8.spi_sio_i = {3'b000, sio0};

  sockit_spi_flash_rsp #(.AW(24), .SYN(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sockit_spi_flash_rsp #(.AW(8), .SYN(2)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  always #5 clk = ~clk;

  // Memory models with one-cycle read latency, plus event logs.
  logic [23:0] ren_log  [0:255];
  logic [23:0] ren8_log [0:255];
  int ren_n = 0, ren8_n = 0, err_n = 0, se_n = 0;

  always @(posedge clk) begin
    if (bus.mem_ren) begin
      bus.mem_rdt <= mem[bus.mem_adr[7:0]];
      ren_log[ren_n] <= bus.mem_adr;
      ren_n <= ren_n + 1;
    end
    if (bus8.mem_ren) begin
      bus8.mem_rdt <= mem[bus8.mem_adr];
      ren8_log[ren8_n] <= {16'h0000, bus8.mem_adr};
      ren8_n <= ren8_n + 1;
    end
    if (bus.err_cmd) err_n <= err_n + 1;
    if (bus.spi_sio_e != 4'h0) se_n <= se_n + 1;
  end

  int n_vec = 0, n_err = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] rx, rx8, rxq;
  logic [3:0]  se_and;
  int r0, r80, e0, s0;

  // One transaction: first nhdr bits of {cmd, adr, dummy}, then ndat data clocks.
  // The closing sclk fall coincides with cs_n rise unless keep_cs is set.
  task automatic txn(input logic [7:0] cmd, input logic [23:0] adr, input int nhdr,
                     input int ndat, input bit keep_cs);
    logic [39:0] hdr;
    int nb;
    hdr = {cmd, adr, 8'h00};
    nb  = nhdr + ndat;
    rx = '0; rx8 = '0; rxq = '0; se_and = 4'hF;
    r0 = ren_n; r80 = ren8_n; e0 = err_n; s0 = se_n;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      sio0 = (i < nhdr) ? hdr[39-i] : 1'b0;
      repeat (H) @(negedge clk);
      if (i >= nhdr) begin
        rx     = {rx[30:0], bus.spi_sio_o[1]};
        rx8    = {rx8[30:0], bus8.spi_sio_o[1]};
        rxq    = {rxq[27:0], bus.spi_sio_o};
        se_and = se_and & bus.spi_sio_e;
      end
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
      if (i == nb - 1 && !keep_cs) cs_n = 1'b1;
    end
    if (!keep_cs) repeat (8) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C; mem[8'h12] = 8'hFF; mem[8'h13] = 8'h00;
    mem[8'hFF] = 8'h81; mem[8'h00] = 8'h7E;
    mem[8'h20] = 8'h5A; mem[8'h21] = 8'hC3;

    repeat (3) @(negedge clk);
    check_vec("rst_sio_o", 32'(bus.spi_sio_o), 32'h0);
    check_vec("rst_sio_e", 32'(bus.spi_sio_e), 32'h0);
    check_vec("rst_ren",   32'(bus.mem_ren),   32'h0);
    check_vec("rst_adr",   32'(bus.mem_adr),   32'h0);
    check_vec("rst_err",   32'(bus.err_cmd),   32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic fast read of four bytes.
    txn(8'h0B, 24'h000010, 40, 32, 1'b0);
    check_vec("rd_data", rx, 32'hA53CFF00);
    check_vec("rd_ren_cnt", 32'(ren_n - r0), 32'd5);
    for (int i = 0; i < 5; i++) check_vec("rd_ren_adr", 32'(ren_log[r0+i]), 32'h10 + 32'(i));
    check_vec("rd_adr_end", 32'(bus.mem_adr), 32'h14);
    check_vec("rd_err", 32'(err_n - e0), 32'd0);

    // Unsupported command.
    txn(8'h9F, 24'h000010, 40, 16, 1'b0);
    check_vec("9f_err", 32'(err_n - e0), 32'd1);
    check_vec("9f_se",  32'(se_n - s0), 32'd0);
    check_vec("9f_ren", 32'(ren_n - r0), 32'd0);
    check_vec("9f_out", rx[15:0], 32'h0);
    txn(8'h0B, 24'h000012, 40, 16, 1'b0);
    check_vec("after9f_data", rx[15:0], 32'hFF00);

    // Deselect in the middle of the address.
    txn(8'h0B, 24'h000010, 20, 0, 1'b0);
    check_vec("abort_ren", 32'(ren_n - r0), 32'd0);
    check_vec("abort_se",  32'(se_n - s0), 32'd0);
    check_vec("abort_err", 32'(err_n - e0), 32'd0);
    txn(8'h0B, 24'h000011, 40, 8, 1'b0);
    check_vec("after_abort", rx[7:0], 32'h3C);

    // Address wrap on the 8-bit instance; upper address bits ignored.
    txn(8'h0B, 24'hAB12FF, 40, 16, 1'b0);
    check_vec("wrap8_adr0", 32'(ren8_log[r80]),   32'hFF);
    check_vec("wrap8_adr1", 32'(ren8_log[r80+1]), 32'h00);
    check_vec("wrap8_data", rx8[15:0], 32'h817E);
    check_vec("wrap24_adr1", 32'(ren_log[r0+1]), 32'hAB1300);
    check_vec("wrap24_data", rx[15:0], 32'h817E);

    // Quad output fast read.
    txn(8'h6B, 24'h000020, 40, 4, 1'b0);
`ifdef SOCKIT_SPI_FLASH_QUAD_EN
    check_vec("quad_data", rxq[15:0], 32'h5AC3);
    check_vec("quad_se",   32'(se_and), 32'hF);
    check_vec("quad_err",  32'(err_n - e0), 32'd0);
`else
    check_vec("6b_err", 32'(err_n - e0), 32'd1);
    check_vec("6b_se",  32'(se_n - s0), 32'd0);
`endif

    // Reset while streaming data.
    txn(8'h0B, 24'h000010, 40, 4, 1'b1);
    check_vec("middat_se", 32'(bus.spi_sio_e), 32'h2);
    rst_n = 1'b0;
    @(negedge clk);
    check_vec("mrst_sio_o", 32'(bus.spi_sio_o), 32'h0);
    check_vec("mrst_sio_e", 32'(bus.spi_sio_e), 32'h0);
    check_vec("mrst_ren",   32'(bus.mem_ren),   32'h0);
    check_vec("mrst_adr",   32'(bus.mem_adr),   32'h0);
    check_vec("mrst_err",   32'(bus.err_cmd),   32'h0);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    txn(8'h0B, 24'h000010, 40, 8, 1'b0);
    check_vec("after_rst", rx[7:0], 32'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
